bnn_conv_sequencer: RTL and testbench

//   Multi-cycle controller for the custom BNN instructions (opcode 7'b1111111).

---
 rtl/bnn_conv_sequencer.sv | 154 +++++++++++++++
 tb/tb_bnn_conv_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_sequencer.sv
// Multi-cycle sequencer for the BNN custom instructions: holds matrix-size and threshold
// config, and computes a row-serial XNOR-popcount while stalling F/D/E.
module bnn_conv_sequencer #(
   parameter int XLEN  = 32,
   parameter int MAX_N = 5,
   parameter int N_W   = 3,
   parameter int ACC_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ms_WE_E,
   input  logic              at_WE_E,
   input  logic [XLEN-1:0]   cfg_data_E,
   input  logic              start_E,
   input  logic              en_threshold_E,
   input  logic [XLEN-1:0]   opA_E,
   input  logic [XLEN-1:0]   opB_E,
   output logic              stall,
   output logic              busy,
   output logic              result_valid,
   output logic [XLEN-1:0]   result,
   output logic [N_W-1:0]    ms_q,
   output logic [ACC_W-1:0]  thr_q
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [N_W-1:0]   ms_d, n_q, n_d, row_q, row_d;
   logic [ACC_W-1:0] thr_d, acc_q, acc_d;
   logic [XLEN-1:0]  vec_q, vec_d, result_q, result_d;
   logic             mode_q, mode_d;

   function automatic logic [XLEN-1:0] low_mask(input logic [N_W-1:0] n);
      logic [ACC_W-1:0] nn;
      logic [XLEN-1:0]  m;
      nn = ACC_W'(n) * ACC_W'(n);
      m  = '0;
      for (int i = 0; i < XLEN; i++) begin
         m[i] = (32'(i) < 32'(nn));
      end
      return m;
   endfunction

   function automatic logic [ACC_W-1:0] row_pop(input logic [XLEN-1:0] v,
                                                input logic [N_W-1:0]  n);
      logic [ACC_W-1:0] c;
      c = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (32'(i) < 32'(n)) begin
            c = c + ACC_W'(v[i]);
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   // Next-state: config writes first, so a BNN finishing this cycle sees the new threshold.
   always_comb begin
      ms_d     = ms_q;
      thr_d    = thr_q;
      state_d  = state_q;
      n_d      = n_q;
      row_d    = row_q;
      acc_d    = acc_q;
      vec_d    = vec_q;
      mode_d   = mode_q;
      result_d = result_q;

      if (ms_WE_E) begin
         if (cfg_data_E == '0) begin
            ms_d = ms_q;
         end else if (cfg_data_E > XLEN'(MAX_N)) begin
            ms_d = N_W'(MAX_N);
         end else begin
            ms_d = cfg_data_E[N_W-1:0];
         end
      end else begin
         ms_d = ms_q;
      end

      if (at_WE_E) begin
         thr_d = cfg_data_E[ACC_W-1:0];
      end else begin
         thr_d = thr_q;
      end

      case (state_q)
         IDLE: begin
            if (start_E) begin
               n_d     = ms_q;
               vec_d   = ~(opA_E ^ opB_E) & low_mask(ms_q);
               mode_d  = en_threshold_E;
               acc_d   = '0;
               row_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = acc_q + row_pop(vec_q, n_q);
            vec_d = vec_q >> n_q;
            row_d = row_q + N_W'(1);
            if (row_q == n_q - N_W'(1)) begin
               state_d  = DONE;
               result_d = mode_q ? XLEN'(acc_d >= thr_d) : XLEN'(acc_d);
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         ms_q     <= N_W'(3);
         thr_q    <= '0;
         n_q      <= '0;
         row_q    <= '0;
         acc_q    <= '0;
         vec_q    <= '0;
         mode_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ms_q     <= ms_d;
         thr_q    <= thr_d;
         n_q      <= n_d;
         row_q    <= row_d;
         acc_q    <= acc_d;
         vec_q    <= vec_d;
         mode_q   <= mode_d;
         result_q <= result_d;
      end
   end

   assign stall        = ~reset & ((state_q == RUN) | ((state_q == IDLE) & start_E));
   assign busy         = (state_q != IDLE);
   assign result_valid = (state_q == DONE);
   assign result       = result_q;

endmodule

// File: tb/tb_bnn_conv_sequencer.sv
// Randomized self-checking bench for bnn_conv_sequencer against a whole-operation
// popcount model with cycle-exact latency checks.
module tb_bnn_conv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_WE_E, at_WE_E, start_E, en_threshold_E;
   logic [31:0] cfg_data_E, opA_E, opB_E;
   logic        stall, busy, result_valid;
   logic [31:0] result;
   logic [2:0]  ms_q;
   logic [5:0]  thr_q;

   int n_cmp = 0;
   int n_bad = 0;

   int          ms_m;
   int          thr_m;
   logic [31:0] last_res;

   bnn_conv_sequencer dut (
      .clk(clk), .reset(reset), .ms_WE_E(ms_WE_E), .at_WE_E(at_WE_E),
      .cfg_data_E(cfg_data_E), .start_E(start_E), .en_threshold_E(en_threshold_E),
      .opA_E(opA_E), .opB_E(opB_E), .stall(stall), .busy(busy),
      .result_valid(result_valid), .result(result), .ms_q(ms_q), .thr_q(thr_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ms_rule(input int cur, input logic [31:0] cfg);
      if (cfg == 32'd0) return cur;
      if (cfg > 32'd5) return 5;
      return int'(cfg);
   endfunction

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int n, input logic mode, input int thr);
      logic [63:0] v;
      int pc;
      v  = {32'd0, ~(a ^ b)} & ((64'd1 << (n * n)) - 64'd1);
      pc = $countones(v);
      return mode ? ((pc >= thr) ? 32'd1 : 32'd0) : 32'(pc);
   endfunction

   task automatic cfg_write(input logic ms_en, input logic at_en, input logic [31:0] d);
      ms_WE_E = ms_en; at_WE_E = at_en; cfg_data_E = d;
      if (ms_en) ms_m = ms_rule(ms_m, d);
      if (at_en) thr_m = int'(d[5:0]);
      tick();
      ms_WE_E = 1'b0; at_WE_E = 1'b0;
      @(negedge clk);
      check("ms_q", 32'(ms_q), 32'(ms_m));
      check("thr_q", 32'(thr_q), 32'(thr_m));
      tick();
   endtask

   // Called at posedge+1 of the issue cycle; run_wr selects a RUN cycle (1..n) for a threshold write.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic mode, input logic ms_en, input logic [31:0] ms_val,
                        input int run_wr, input logic [5:0] thr_val, input logic hold);
      int n;
      logic [31:0] exp;
      n = ms_m;
      start_E = 1'b1; opA_E = a; opB_E = b; en_threshold_E = mode;
      ms_WE_E = ms_en; cfg_data_E = ms_val;
      if (ms_en) ms_m = ms_rule(ms_m, ms_val);
      @(negedge clk);
      check({tag, ":stall_t"}, 32'(stall), 32'd1);
      check({tag, ":busy_t"}, 32'(busy), 32'd0);
      tick();
      ms_WE_E = 1'b0;
      if (!hold) begin
         start_E = 1'b0;
         opA_E = $urandom; opB_E = $urandom;
      end
      for (int k = 1; k <= n; k++) begin
         if (k == run_wr) begin
            at_WE_E = 1'b1; cfg_data_E = 32'(thr_val); thr_m = int'(thr_val);
         end
         @(negedge clk);
         check({tag, ":stall_run"}, 32'(stall), 32'd1);
         check({tag, ":valid_run"}, 32'(result_valid), 32'd0);
         tick();
         at_WE_E = 1'b0;
      end
      exp = model(a, b, n, mode, thr_m);
      @(negedge clk);
      check({tag, ":valid_done"}, 32'(result_valid), 32'd1);
      check({tag, ":stall_done"}, 32'(stall), 32'd0);
      check({tag, ":result"}, result, exp);
      tick();
      start_E = 1'b0;
      @(negedge clk);
      check({tag, ":busy_after"}, 32'(busy), 32'd0);
      check({tag, ":valid_after"}, 32'(result_valid), 32'd0);
      check({tag, ":hold"}, result, exp);
      last_res = exp;
      tick();
   endtask

   initial begin
      reset = 1'b1; ms_WE_E = 1'b0; at_WE_E = 1'b0; start_E = 1'b0;
      en_threshold_E = 1'b0; cfg_data_E = '0; opA_E = '0; opB_E = '0;
      ms_m = 3; thr_m = 0; last_res = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst:ms_q", 32'(ms_q), 32'd3);
      check("rst:thr_q", 32'(thr_q), 32'd0);
      check("rst:stall", 32'(stall), 32'd0);
      check("rst:valid", 32'(result_valid), 32'd0);
      check("rst:result", result, 32'd0);
      check("rst:busy", 32'(busy), 32'd0);
      tick();

      do_op("bcnv3", 32'h1FF, 32'h1FF, 1'b0, 1'b0, 32'd0, 0, 6'd0, 1'b1);
      check("bcnv3_is9", last_res, 32'd9);
      cfg_write(1'b0, 1'b1, 32'd5);
      do_op("bnn_t5", 32'h1FF, 32'h00F, 1'b1, 1'b0, 32'd0, 0, 6'd0, 1'b1);
      cfg_write(1'b0, 1'b1, 32'd4);
      do_op("bnn_t4", 32'h1FF, 32'h00F, 1'b1, 1'b0, 32'd0, 0, 6'd0, 1'b1);
      cfg_write(1'b1, 1'b0, 32'd0);
      cfg_write(1'b1, 1'b0, 32'd9);
      do_op("bcnv5", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0, 6'd0, 1'b1);
      do_op("ms2_same", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd2, 0, 6'd0, 1'b1);
      do_op("ms2_next", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0, 6'd0, 1'b0);
      cfg_write(1'b1, 1'b0, 32'd3);
      do_op("thr_run", 32'h0FF, 32'h0FF, 1'b1, 1'b0, 32'd0, 3, 6'd9, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] msv;
         int rw;
         msv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : ms_m;
         rw  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ms_m)) : 0;
         do_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), msv, rw, 6'($urandom_range(0, 26)),
               1'($urandom_range(0, 1)));
      end

      // Abort during the second RUN cycle.
      cfg_write(1'b1, 1'b1, 32'd4);
      start_E = 1'b1; opA_E = 32'hFFFF; opB_E = 32'hFFFF; en_threshold_E = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("abort:stall_pre", 32'(stall), 32'd1);
      reset = 1'b1;
      #1;
      check("abort:stall", 32'(stall), 32'd0);
      check("abort:valid", 32'(result_valid), 32'd0);
      check("abort:ms_q", 32'(ms_q), 32'd3);
      check("abort:thr_q", 32'(thr_q), 32'd0);
      start_E = 1'b0;
      tick();
      reset = 1'b0;
      ms_m = 3; thr_m = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("abort:no_valid", 32'(result_valid), 32'd0);
         check("abort:idle", 32'(busy), 32'd0);
      end
      check("abort:result", result, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
